match_ctrl: RTL and testbench

//  Pong match sequencer between keypad/wall-hit sources and pixel_generation, dot_matrix, seven-seg.

---
 rtl/match_ctrl_pkg.sv | 16 +
 rtl/match_ctrl_sec_tick_gen.sv | 18 +
 rtl/match_ctrl.sv | 129 ++++++++++++
 tb/tb_match_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/match_ctrl_pkg.sv
// match_ctrl_pkg: state encoding, counter widths and BCD helper shared by match_ctrl and display logic.
package match_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;
  localparam int SCORE_W = 4;
  localparam int BCD_W   = 8;
  // Two-digit BCD increment that sticks at 99.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    return v == 8'h99 ? v : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/match_ctrl_sec_tick_gen.sv
// sec_tick_gen: prescaler 0..TICK_DIV-1 with synchronous clear and freeze, 1-cycle tick on wrap.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] r_cnt;
  assign o_tick = i_en && r_cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk_50MHz or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_clr || o_tick) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: Pong match sequencer (IDLE/SERVE/PLAY/POINT/OVER), scores and BCD play timer.
// Optional MATCH_PAUSE_EN adds a pause toggle during PLAY.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int SERVE_SEC = 2,
  parameter int POINT_SEC = 1,
  parameter int WIN_SCORE = 5
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               left_wall_hit,
  input  logic               right_wall_hit,
  input  logic               pause,
  output logic               play_en,
  output logic               ball_rst,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [BCD_W-1:0]   sec_bcd,
  output logic [2:0]         state_o,
  output logic               game_over,
  output logic               winner
);
  state_t             r_state, w_next;
  logic               r_start_q, r_lh_q, r_rh_q;
  logic               r_ball_rst, r_serve_dir, r_winner;
  logic [SCORE_W-1:0] r_score_l, r_score_r;
  logic [BCD_W-1:0]   r_sec;
  logic [7:0]         r_hold, w_hold_tgt;
  logic               w_start_r, w_hit_l, w_hit_r, w_restart;
  logic               w_tick, w_clr, w_hold_done, w_paused, w_won;

  assign w_start_r   = start && !r_start_q;
  assign w_restart   = w_start_r && (r_state == S_IDLE || r_state == S_OVER);
  // Simultaneous wall rises cancel each other out.
  assign w_hit_l     = r_state == S_PLAY && !w_paused && left_wall_hit && !r_lh_q && !(right_wall_hit && !r_rh_q);
  assign w_hit_r     = r_state == S_PLAY && !w_paused && right_wall_hit && !r_rh_q && !(left_wall_hit && !r_lh_q);
  assign w_hold_tgt  = r_state == S_SERVE ? 8'(SERVE_SEC - 1) : 8'(POINT_SEC - 1);
  assign w_hold_done = w_tick && r_hold == w_hold_tgt;
  assign w_won       = r_score_l == SCORE_W'(WIN_SCORE) || r_score_r == SCORE_W'(WIN_SCORE);
  assign w_clr       = w_next != r_state;

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_en     (!w_paused),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_OVER: w_next = w_start_r ? S_SERVE : r_state;
      S_SERVE:        w_next = w_hold_done ? S_PLAY : S_SERVE;
      S_PLAY:         w_next = (w_hit_l || w_hit_r) ? S_POINT : S_PLAY;
      S_POINT:        w_next = !w_hold_done ? S_POINT : w_won ? S_OVER : S_SERVE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset)
    if (!reset) begin
      r_state     <= S_IDLE;
      r_start_q   <= 1'b0;
      r_lh_q      <= 1'b0;
      r_rh_q      <= 1'b0;
      r_ball_rst  <= 1'b0;
      r_serve_dir <= 1'b0;
      r_winner    <= 1'b0;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_sec       <= '0;
      r_hold      <= '0;
    end else begin
      r_state    <= w_next;
      r_start_q  <= start;
      r_lh_q     <= left_wall_hit;
      r_rh_q     <= right_wall_hit;
      r_ball_rst <= w_next == S_SERVE && r_state != S_SERVE;
      r_hold     <= w_clr ? 8'd0 : w_tick ? r_hold + 8'd1 : r_hold;
      if (w_restart) begin
        r_score_l   <= '0;
        r_score_r   <= '0;
        r_sec       <= '0;
        r_serve_dir <= 1'b0;
      end
      if (w_hit_l) begin
        r_score_r   <= r_score_r + 1'b1;
        r_serve_dir <= 1'b0;
      end
      if (w_hit_r) begin
        r_score_l   <= r_score_l + 1'b1;
        r_serve_dir <= 1'b1;
      end
      if (r_state == S_PLAY && w_tick) r_sec <= bcd_inc(r_sec);
      if (r_state == S_POINT && w_next == S_OVER) r_winner <= r_score_r == SCORE_W'(WIN_SCORE);
    end

`ifdef MATCH_PAUSE_EN
  logic r_pause_q, r_paused;
  assign w_paused = r_paused;
  always_ff @(posedge clk_50MHz or negedge reset)
    if (!reset) begin
      r_pause_q <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_pause_q <= pause;
      r_paused  <= w_next != S_PLAY ? 1'b0 : (r_state == S_PLAY && pause && !r_pause_q) ? !r_paused : r_paused;
    end
`else
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_paused       = 1'b0;
`endif

  assign play_en   = r_state == S_PLAY && !w_paused;
  assign ball_rst  = r_ball_rst;
  assign serve_dir = r_serve_dir;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign sec_bcd   = r_sec;
  assign state_o   = r_state;
  assign game_over = r_state == S_OVER;
  assign winner    = r_winner;
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: table-driven match flow plus hand sequences for timer, pause and async reset.
module tb_match_ctrl;
  logic       clk = 1'b0, reset = 1'b0;
  logic       start = 1'b0, lh = 1'b0, rh = 1'b0, pause = 1'b0;
  logic       play_en, ball_rst, serve_dir, game_over, winner;
  logic [3:0] score_l, score_r;
  logic [7:0] sec_bcd;
  logic [2:0] state_o;
  int         n_tests = 0, n_fail = 0;

  match_ctrl #(.TICK_DIV(4), .SERVE_SEC(2), .POINT_SEC(1), .WIN_SCORE(2)) dut (
    .clk_50MHz(clk), .reset(reset), .start(start), .left_wall_hit(lh), .right_wall_hit(rh),
    .pause(pause), .play_en(play_en), .ball_rst(ball_rst), .serve_dir(serve_dir),
    .score_l(score_l), .score_r(score_r), .sec_bcd(sec_bcd), .state_o(state_o),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // in = {start, left, right}; fl = {serve_dir, play_en, game_over, ball_rst, winner}
  typedef struct {
    logic [2:0] in;
    int         n;
    logic [2:0] st;
    logic [3:0] sl, sr;
    logic [4:0] fl;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{3'b000, 1, 3'd0, 4'd0, 4'd0, 5'b00000};
    tbl[1]  = '{3'b100, 1, 3'd1, 4'd0, 4'd0, 5'b00010};
    tbl[2]  = '{3'b000, 1, 3'd1, 4'd0, 4'd0, 5'b00000};
    tbl[3]  = '{3'b000, 6, 3'd1, 4'd0, 4'd0, 5'b00000};
    tbl[4]  = '{3'b000, 1, 3'd2, 4'd0, 4'd0, 5'b01000};
    tbl[5]  = '{3'b001, 1, 3'd3, 4'd1, 4'd0, 5'b10000};
    tbl[6]  = '{3'b001, 3, 3'd3, 4'd1, 4'd0, 5'b10000};
    tbl[7]  = '{3'b001, 1, 3'd1, 4'd1, 4'd0, 5'b10010};
    tbl[8]  = '{3'b001, 5, 3'd1, 4'd1, 4'd0, 5'b10000};
    tbl[9]  = '{3'b000, 3, 3'd2, 4'd1, 4'd0, 5'b11000};
    tbl[10] = '{3'b010, 1, 3'd3, 4'd1, 4'd1, 5'b00000};
    tbl[11] = '{3'b000, 4, 3'd1, 4'd1, 4'd1, 5'b00010};
    tbl[12] = '{3'b000, 8, 3'd2, 4'd1, 4'd1, 5'b01000};
    tbl[13] = '{3'b010, 1, 3'd3, 4'd1, 4'd2, 5'b00000};
    tbl[14] = '{3'b000, 3, 3'd3, 4'd1, 4'd2, 5'b00000};
    tbl[15] = '{3'b000, 1, 3'd4, 4'd1, 4'd2, 5'b00101};
    tbl[16] = '{3'b010, 2, 3'd4, 4'd1, 4'd2, 5'b00101};
    tbl[17] = '{3'b100, 1, 3'd1, 4'd0, 4'd0, 5'b00010};
    tbl[18] = '{3'b000, 8, 3'd2, 4'd0, 4'd0, 5'b01000};
    tbl[19] = '{3'b100, 1, 3'd2, 4'd0, 4'd0, 5'b01000};

    step(3);
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_outs", 8'({play_en, ball_rst, serve_dir, game_over, winner}), 8'd0);
    reset = 1'b1;
    step(1);

    for (int i = 0; i < 20; i++) begin
      {start, lh, rh} = tbl[i].in;
      step(tbl[i].n);
      chk($sformatf("v%0d_state", i), 8'(state_o), 8'(tbl[i].st));
      chk($sformatf("v%0d_score_l", i), 8'(score_l), 8'(tbl[i].sl));
      chk($sformatf("v%0d_score_r", i), 8'(score_r), 8'(tbl[i].sr));
      chk($sformatf("v%0d_flags", i), 8'({serve_dir, play_en, game_over, ball_rst}), 8'(tbl[i].fl[4:1]));
      if (tbl[i].fl[2]) chk($sformatf("v%0d_winner", i), 8'(winner), 8'(tbl[i].fl[0]));
    end

    // both walls rise together: ignored
    start = 1'b0; lh = 1'b1; rh = 1'b1;
    step(1);
    chk("both_state", 8'(state_o), 8'd2);
    chk("both_scores", {score_l, score_r}, 8'h00);
    lh = 1'b0; rh = 1'b0;
    step(2);
    chk("sec_first", sec_bcd, 8'h01);
    step(36);
    chk("sec_carry", sec_bcd, 8'h10);

    pause = 1'b1;
    step(1);
`ifdef MATCH_PAUSE_EN
    chk("pause_play_en", 8'(play_en), 8'd0);
    step(20);
    chk("pause_frozen", sec_bcd, 8'h10);
    chk("pause_state", 8'(state_o), 8'd2);
    pause = 1'b0;
    step(1);
    pause = 1'b1;
    step(1);
`endif
    chk("unpaused_play_en", 8'(play_en), 8'd1);
    pause = 1'b0;
    step(420);
    chk("sec_sat", sec_bcd, 8'h99);

    rh = 1'b1;
    step(1);
    chk("pt_state", 8'(state_o), 8'd3);
    chk("pt_score_l", 8'(score_l), 8'd1);
    rh = 1'b0;
    step(12);
    chk("replay_state", 8'(state_o), 8'd2);
    chk("sec_kept", sec_bcd, 8'h99);

    // asynchronous reset mid-PLAY
    #3 reset = 1'b0;
    #1;
    chk("arst_state", 8'(state_o), 8'd0);
    chk("arst_scores", {score_l, score_r}, 8'h00);
    chk("arst_sec", sec_bcd, 8'h00);
    chk("arst_outs", 8'({play_en, ball_rst, serve_dir, game_over, winner}), 8'd0);
    step(1);
    reset = 1'b1;
    step(2);
    chk("post_rst_idle", 8'(state_o), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
